ycr1_dmem_router: RTL and testbench



---
 rtl/ycr1_dmem_router_pkg.sv | 40 ++++
 rtl/ycr1_dmem_router_ofifo.sv | 72 +++++++
 rtl/ycr1_dmem_router.sv | 157 +++++++++++++++
 tb/tb_ycr1_dmem_router.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ycr1_dmem_router_pkg.sv
// Shared types and constants for the data-memory router.
// The optional registered response path is enabled by defining
// YCR1_DMEM_ROUTER_RESP_REG_EN; see ycr1_dmem_router.sv.

`ifndef YCR1_DMEM_AWIDTH
`define YCR1_DMEM_AWIDTH 32
`endif
`ifndef YCR1_DMEM_DWIDTH
`define YCR1_DMEM_DWIDTH 32
`endif

package ycr1_dmem_router_pkg;

  // Target identifiers stored in the order FIFO.
  typedef enum logic {
    YCR1_DMEM_TGT_TMR = 1'b0,
    YCR1_DMEM_TGT_EXT = 1'b1
  } type_ycr1_dmem_tgt_e;

  // Memory interface response encodings shared with the core memif.
  typedef enum logic [1:0] {
    YCR1_MEM_RESP_NOTRDY = 2'b00,
    YCR1_MEM_RESP_RDY_OK = 2'b01,
    YCR1_MEM_RESP_RDY_ER = 2'b10
  } type_ycr1_mem_resp_e;

  // Default timer register window: 32 bytes at 0x0C00_0000.
  localparam logic [31:0] YCR1_DMEM_ROUTER_TIMER_BASE = 32'h0C00_0000;
  localparam logic [31:0] YCR1_DMEM_ROUTER_TIMER_MASK = 32'hFFFF_FFE0;

  // True when the masked address falls inside the window at base.
  function automatic logic ycr1_dmem_addr_hit(
    input logic [`YCR1_DMEM_AWIDTH-1:0] addr,
    input logic [`YCR1_DMEM_AWIDTH-1:0] base,
    input logic [`YCR1_DMEM_AWIDTH-1:0] mask
  );
    return ((addr & mask) == base);
  endfunction

endpackage

// File: rtl/ycr1_dmem_router_ofifo.sv
// In-order FIFO of target ids for outstanding accepted requests.
// A push while full is accepted only when a pop happens in the same cycle,
// which keeps the occupancy unchanged and advances both pointers.

module ycr1_dmem_router_ofifo
  import ycr1_dmem_router_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] mem_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and counter state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Id storage; written only on an accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/ycr1_dmem_router.sv
// Data-memory router: timer window (port 0) versus the rest of the fabric
// (port 1). Requests are routed with no added latency; responses return in
// request order, selected by the head of the order FIFO.
// Define YCR1_DMEM_ROUTER_RESP_REG_EN to register the core response path
// (+1 cycle response latency, pop timing unchanged).
//
// Handshake: a request is transferred when core_dmem_req and
// core_dmem_req_ack are both high in one cycle; the core keeps the request
// stable until then. A response is consumed in any cycle where the head
// target's resp is not NOTRDY. Responses from a target that is not at the
// head are ignored and stay pending at that target.

`ifndef YCR1_DMEM_AWIDTH
`define YCR1_DMEM_AWIDTH 32
`endif
`ifndef YCR1_DMEM_DWIDTH
`define YCR1_DMEM_DWIDTH 32
`endif

module ycr1_dmem_router
  import ycr1_dmem_router_pkg::*;
#(
  parameter logic [`YCR1_DMEM_AWIDTH-1:0] TIMER_BASE    = YCR1_DMEM_ROUTER_TIMER_BASE,
  parameter logic [`YCR1_DMEM_AWIDTH-1:0] TIMER_MASK    = YCR1_DMEM_ROUTER_TIMER_MASK,
  parameter int                           OUTSTND_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  // Core side
  input  logic                         core_dmem_req,
  input  logic                         core_dmem_cmd,
  input  logic [1:0]                   core_dmem_width,
  input  logic [`YCR1_DMEM_AWIDTH-1:0] core_dmem_addr,
  input  logic [`YCR1_DMEM_DWIDTH-1:0] core_dmem_wdata,
  output logic                         core_dmem_req_ack,
  output logic [`YCR1_DMEM_DWIDTH-1:0] core_dmem_rdata,
  output logic [1:0]                   core_dmem_resp,
  // Timer side
  output logic                         tmr_dmem_req,
  output logic                         tmr_dmem_cmd,
  output logic [1:0]                   tmr_dmem_width,
  output logic [`YCR1_DMEM_AWIDTH-1:0] tmr_dmem_addr,
  output logic [`YCR1_DMEM_DWIDTH-1:0] tmr_dmem_wdata,
  input  logic                         tmr_dmem_req_ack,
  input  logic [`YCR1_DMEM_DWIDTH-1:0] tmr_dmem_rdata,
  input  logic [1:0]                   tmr_dmem_resp,
  // Fabric side
  output logic                         ext_dmem_req,
  output logic                         ext_dmem_cmd,
  output logic [1:0]                   ext_dmem_width,
  output logic [`YCR1_DMEM_AWIDTH-1:0] ext_dmem_addr,
  output logic [`YCR1_DMEM_DWIDTH-1:0] ext_dmem_wdata,
  input  logic                         ext_dmem_req_ack,
  input  logic [`YCR1_DMEM_DWIDTH-1:0] ext_dmem_rdata,
  input  logic [1:0]                   ext_dmem_resp
);

  logic                         sel_tmr;
  logic                         fifo_push;
  logic                         fifo_pop;
  logic                         fifo_din;
  logic                         fifo_head;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic                         req_open;
  logic [1:0]                   head_resp;
  logic [`YCR1_DMEM_DWIDTH-1:0] head_rdata;

  // Address decode.
  assign sel_tmr = ycr1_dmem_addr_hit(core_dmem_addr, TIMER_BASE, TIMER_MASK);

  // A slot is available when not full, or when the head retires this cycle.
  assign req_open = ~fifo_full | fifo_pop;

  // Request payload is broadcast; only the selected target sees req.
  assign tmr_dmem_cmd   = core_dmem_cmd;
  assign tmr_dmem_width = core_dmem_width;
  assign tmr_dmem_addr  = core_dmem_addr;
  assign tmr_dmem_wdata = core_dmem_wdata;
  assign ext_dmem_cmd   = core_dmem_cmd;
  assign ext_dmem_width = core_dmem_width;
  assign ext_dmem_addr  = core_dmem_addr;
  assign ext_dmem_wdata = core_dmem_wdata;

  assign tmr_dmem_req = core_dmem_req &  sel_tmr & req_open;
  assign ext_dmem_req = core_dmem_req & ~sel_tmr & req_open;

  assign core_dmem_req_ack = (sel_tmr ? tmr_dmem_req_ack : ext_dmem_req_ack)
                             & core_dmem_req & req_open;

  // Every accepted request records which target owes the response.
  assign fifo_push = core_dmem_req & core_dmem_req_ack;
  assign fifo_din  = sel_tmr ? YCR1_DMEM_TGT_TMR : YCR1_DMEM_TGT_EXT;

  // Head-of-queue response select; nothing is visible while empty.
  always_comb begin
    head_resp  = YCR1_MEM_RESP_NOTRDY;
    head_rdata = '0;
    if (!fifo_empty) begin
      if (fifo_head == YCR1_DMEM_TGT_EXT) begin
        head_resp  = ext_dmem_resp;
        head_rdata = ext_dmem_rdata;
      end else begin
        head_resp  = tmr_dmem_resp;
        head_rdata = tmr_dmem_rdata;
      end
    end
  end

  assign fifo_pop = ~fifo_empty & (head_resp != YCR1_MEM_RESP_NOTRDY);

  ycr1_dmem_router_ofifo #(
    .DEPTH (OUTSTND_DEPTH)
  ) i_ofifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef YCR1_DMEM_ROUTER_RESP_REG_EN
  logic [1:0]                   resp_q, resp_d;
  logic [`YCR1_DMEM_DWIDTH-1:0] rdata_q, rdata_d;

  // Capture the retiring response; idle cycles fall back to NOTRDY / 0.
  always_comb begin
    resp_d  = YCR1_MEM_RESP_NOTRDY;
    rdata_d = '0;
    if (fifo_pop) begin
      resp_d  = head_resp;
      rdata_d = head_rdata;
    end
  end

  // Registered response toward the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_q  <= YCR1_MEM_RESP_NOTRDY;
      rdata_q <= '0;
    end else begin
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  assign core_dmem_resp  = resp_q;
  assign core_dmem_rdata = rdata_q;
`else
  assign core_dmem_resp  = head_resp;
  assign core_dmem_rdata = head_rdata;
`endif

endmodule

// File: tb/tb_ycr1_dmem_router.sv
// Directed bench for ycr1_dmem_router: timer/fabric routing, response
// ordering, full-queue stall with same-cycle refill, and async reset.

`ifndef YCR1_DMEM_AWIDTH
`define YCR1_DMEM_AWIDTH 32
`endif
`ifndef YCR1_DMEM_DWIDTH
`define YCR1_DMEM_DWIDTH 32
`endif

module tb_ycr1_dmem_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_dmem_req;
  logic        core_dmem_cmd;
  logic [1:0]  core_dmem_width;
  logic [31:0] core_dmem_addr;
  logic [31:0] core_dmem_wdata;
  logic        core_dmem_req_ack;
  logic [31:0] core_dmem_rdata;
  logic [1:0]  core_dmem_resp;
  logic        tmr_dmem_req;
  logic        tmr_dmem_cmd;
  logic [1:0]  tmr_dmem_width;
  logic [31:0] tmr_dmem_addr;
  logic [31:0] tmr_dmem_wdata;
  logic        tmr_dmem_req_ack;
  logic [31:0] tmr_dmem_rdata;
  logic [1:0]  tmr_dmem_resp;
  logic        ext_dmem_req;
  logic        ext_dmem_cmd;
  logic [1:0]  ext_dmem_width;
  logic [31:0] ext_dmem_addr;
  logic [31:0] ext_dmem_wdata;
  logic        ext_dmem_req_ack;
  logic [31:0] ext_dmem_rdata;
  logic [1:0]  ext_dmem_resp;

  int total = 0;
  int bad   = 0;

  ycr1_dmem_router dut (
    .clk               (clk),
    .rst               (rst),
    .core_dmem_req     (core_dmem_req),
    .core_dmem_cmd     (core_dmem_cmd),
    .core_dmem_width   (core_dmem_width),
    .core_dmem_addr    (core_dmem_addr),
    .core_dmem_wdata   (core_dmem_wdata),
    .core_dmem_req_ack (core_dmem_req_ack),
    .core_dmem_rdata   (core_dmem_rdata),
    .core_dmem_resp    (core_dmem_resp),
    .tmr_dmem_req      (tmr_dmem_req),
    .tmr_dmem_cmd      (tmr_dmem_cmd),
    .tmr_dmem_width    (tmr_dmem_width),
    .tmr_dmem_addr     (tmr_dmem_addr),
    .tmr_dmem_wdata    (tmr_dmem_wdata),
    .tmr_dmem_req_ack  (tmr_dmem_req_ack),
    .tmr_dmem_rdata    (tmr_dmem_rdata),
    .tmr_dmem_resp     (tmr_dmem_resp),
    .ext_dmem_req      (ext_dmem_req),
    .ext_dmem_cmd      (ext_dmem_cmd),
    .ext_dmem_width    (ext_dmem_width),
    .ext_dmem_addr     (ext_dmem_addr),
    .ext_dmem_wdata    (ext_dmem_wdata),
    .ext_dmem_req_ack  (ext_dmem_req_ack),
    .ext_dmem_rdata    (ext_dmem_rdata),
    .ext_dmem_resp     (ext_dmem_resp)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    core_dmem_req    = 1'b0;
    core_dmem_cmd    = 1'b0;
    core_dmem_width  = 2'b00;
    core_dmem_addr   = 32'h0;
    core_dmem_wdata  = 32'h0;
    tmr_dmem_req_ack = 1'b0;
    tmr_dmem_rdata   = 32'h0;
    tmr_dmem_resp    = 2'b00;
    ext_dmem_req_ack = 1'b0;
    ext_dmem_rdata   = 32'h0;
    ext_dmem_resp    = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #12;
    chk("rst_resp",    32'(core_dmem_resp), 32'h0);
    chk("rst_rdata",   core_dmem_rdata, 32'h0);
    chk("rst_ack",     32'(core_dmem_req_ack), 32'h0);
    chk("rst_tmr_req", 32'(tmr_dmem_req), 32'h0);
    chk("rst_ext_req", 32'(ext_dmem_req), 32'h0);
    step();
    rst = 1'b0;

    // ---- Timer read, timer acks one cycle after req ----
    step();
    core_dmem_req = 1'b1; core_dmem_cmd = 1'b0; core_dmem_width = 2'b10;
    core_dmem_addr = 32'h0C00_0008;
    #1;
    chk("t1_tmr_req",  32'(tmr_dmem_req), 32'h1);
    chk("t1_ext_req",  32'(ext_dmem_req), 32'h0);
    chk("t1_ack_wait", 32'(core_dmem_req_ack), 32'h0);
    chk("t1_tmr_addr", tmr_dmem_addr, 32'h0C00_0008);
    step();
    tmr_dmem_req_ack = 1'b1;
    #1;
    chk("t1_ack", 32'(core_dmem_req_ack), 32'h1);
    step();
    core_dmem_req = 1'b0; tmr_dmem_req_ack = 1'b0;
    tmr_dmem_resp = 2'b01; tmr_dmem_rdata = 32'h0000_1234;
    #1;
`ifdef YCR1_DMEM_ROUTER_RESP_REG_EN
    chk("t1r_resp_early", 32'(core_dmem_resp), 32'h0);
`else
    chk("t1_resp",  32'(core_dmem_resp), 32'h1);
    chk("t1_rdata", core_dmem_rdata, 32'h0000_1234);
`endif
    step();
    tmr_dmem_resp = 2'b00; tmr_dmem_rdata = 32'h0;
    #1;
`ifdef YCR1_DMEM_ROUTER_RESP_REG_EN
    chk("t1r_resp",  32'(core_dmem_resp), 32'h1);
    chk("t1r_rdata", core_dmem_rdata, 32'h0000_1234);
`else
    chk("t1_resp_done", 32'(core_dmem_resp), 32'h0);
`endif
    // Queue must be empty now: a stray fabric response is not forwarded.
    step();
    ext_dmem_resp = 2'b01; ext_dmem_rdata = 32'h0000_FFFF;
    #1;
    chk("t1_empty_resp",  32'(core_dmem_resp), 32'h0);
    chk("t1_empty_rdata", core_dmem_rdata, 32'h0);
    step();
    ext_dmem_resp = 2'b00; ext_dmem_rdata = 32'h0;

    // ---- Fabric write ----
    step();
    core_dmem_req = 1'b1; core_dmem_cmd = 1'b1; core_dmem_width = 2'b10;
    core_dmem_addr = 32'h0000_1000; core_dmem_wdata = 32'hDEAD_BEEF;
    ext_dmem_req_ack = 1'b1;
    #1;
    chk("t2_ext_req",   32'(ext_dmem_req), 32'h1);
    chk("t2_tmr_req",   32'(tmr_dmem_req), 32'h0);
    chk("t2_ext_wdata", ext_dmem_wdata, 32'hDEAD_BEEF);
    chk("t2_ext_cmd",   32'(ext_dmem_cmd), 32'h1);
    chk("t2_ack",       32'(core_dmem_req_ack), 32'h1);
    step();
    core_dmem_req = 1'b0; core_dmem_cmd = 1'b0; ext_dmem_req_ack = 1'b0;
    ext_dmem_resp = 2'b01;
    #1;
`ifdef YCR1_DMEM_ROUTER_RESP_REG_EN
    chk("t2r_resp_early", 32'(core_dmem_resp), 32'h0);
`else
    chk("t2_resp", 32'(core_dmem_resp), 32'h1);
`endif
    step();
    ext_dmem_resp = 2'b00;
    #1;
`ifdef YCR1_DMEM_ROUTER_RESP_REG_EN
    chk("t2r_resp", 32'(core_dmem_resp), 32'h1);
`else
    chk("t2_resp_done", 32'(core_dmem_resp), 32'h0);
`endif

`ifndef YCR1_DMEM_ROUTER_RESP_REG_EN
    // ---- Back-to-back mixed ordering: ext then timer ----
    step(); // c1: ext read accepted
    core_dmem_req = 1'b1; core_dmem_addr = 32'h0000_2000; ext_dmem_req_ack = 1'b1;
    #1;
    chk("t3_ack_ext", 32'(core_dmem_req_ack), 32'h1);
    step(); // c2: timer read waiting
    core_dmem_addr = 32'h0C00_0004; ext_dmem_req_ack = 1'b0;
    #1;
    chk("t3_tmr_req",  32'(tmr_dmem_req), 32'h1);
    chk("t3_ack_wait", 32'(core_dmem_req_ack), 32'h0);
    step(); // c3: timer acks
    tmr_dmem_req_ack = 1'b1;
    #1;
    chk("t3_ack_tmr", 32'(core_dmem_req_ack), 32'h1);
    step(); // c4: timer responds early, held
    core_dmem_req = 1'b0; tmr_dmem_req_ack = 1'b0;
    tmr_dmem_resp = 2'b01; tmr_dmem_rdata = 32'hAAAA_0004;
    #1;
    chk("t3_c4_resp", 32'(core_dmem_resp), 32'h0);
    step(); // c5
    #1;
    chk("t3_c5_resp", 32'(core_dmem_resp), 32'h0);
    step(); // c6: ext responds
    ext_dmem_resp = 2'b01; ext_dmem_rdata = 32'hBBBB_2000;
    #1;
    chk("t3_c6_resp",  32'(core_dmem_resp), 32'h1);
    chk("t3_c6_rdata", core_dmem_rdata, 32'hBBBB_2000);
    step(); // c7: timer data now at head
    ext_dmem_resp = 2'b00; ext_dmem_rdata = 32'h0;
    #1;
    chk("t3_c7_resp",  32'(core_dmem_resp), 32'h1);
    chk("t3_c7_rdata", core_dmem_rdata, 32'hAAAA_0004);
    step(); // c8
    tmr_dmem_resp = 2'b00; tmr_dmem_rdata = 32'h0;
    #1;
    chk("t3_c8_resp", 32'(core_dmem_resp), 32'h0);

    // ---- Full stall with same-cycle refill ----
    step();
    core_dmem_req = 1'b1; core_dmem_addr = 32'h0000_3000; ext_dmem_req_ack = 1'b1;
    #1;
    chk("t4_ack1", 32'(core_dmem_req_ack), 32'h1);
    step();
    core_dmem_addr = 32'h0000_3004;
    #1;
    chk("t4_ack2", 32'(core_dmem_req_ack), 32'h1);
    step();
    core_dmem_addr = 32'h0000_3008;
    #1;
    chk("t4_full_ack", 32'(core_dmem_req_ack), 32'h0);
    chk("t4_full_req", 32'(ext_dmem_req), 32'h0);
    step();
    ext_dmem_resp = 2'b01; ext_dmem_rdata = 32'h1111_3000;
    #1;
    chk("t4_refill_ack",  32'(core_dmem_req_ack), 32'h1);
    chk("t4_refill_req",  32'(ext_dmem_req), 32'h1);
    chk("t4_resp1_rdata", core_dmem_rdata, 32'h1111_3000);
    step();
    core_dmem_req = 1'b0; ext_dmem_req_ack = 1'b0;
    ext_dmem_rdata = 32'h2222_3004;
    #1;
    chk("t4_resp2",       32'(core_dmem_resp), 32'h1);
    chk("t4_resp2_rdata", core_dmem_rdata, 32'h2222_3004);
    step();
    ext_dmem_rdata = 32'h3333_3008;
    #1;
    chk("t4_resp3_rdata", core_dmem_rdata, 32'h3333_3008);
    step();
    #1;
    chk("t4_drained", 32'(core_dmem_resp), 32'h0);
    step();
    ext_dmem_resp = 2'b00; ext_dmem_rdata = 32'h0;
`endif

    // ---- Reset with one outstanding timer entry ----
    step();
    core_dmem_req = 1'b1; core_dmem_cmd = 1'b0; core_dmem_addr = 32'h0C00_0010;
    step();
    tmr_dmem_req_ack = 1'b1;
    #1;
    chk("t5_ack", 32'(core_dmem_req_ack), 32'h1);
    step();
    core_dmem_req = 1'b0; tmr_dmem_req_ack = 1'b0;
    tmr_dmem_resp = 2'b01; tmr_dmem_rdata = 32'h5555_5555;
    #1;
`ifndef YCR1_DMEM_ROUTER_RESP_REG_EN
    chk("t5_pre_rst_resp", 32'(core_dmem_resp), 32'h1);
`endif
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_resp",  32'(core_dmem_resp), 32'h0);
    chk("t5_rst_rdata", core_dmem_rdata, 32'h0);
    chk("t5_rst_ack",   32'(core_dmem_req_ack), 32'h0);
    chk("t5_rst_treq",  32'(tmr_dmem_req), 32'h0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("t5_late_resp",  32'(core_dmem_resp), 32'h0);
    step();
    #1;
    chk("t5_late_resp2", 32'(core_dmem_resp), 32'h0);
    chk("t5_late_rdata", core_dmem_rdata, 32'h0);
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
